uart_rx_core: RTL and testbench

Parametrised UART receiver engine that fills the receive slot of the UART top. It oversamples the serial input with a programmable baud divider and majority-votes three mid-bit samples. Data length, parity mode and stop-bit count are configured at run time. Each received frame, with its error flags, is pushed into the upstream FIFO; the block also reports busy/overrun status to the regmap.

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_baud_gen.sv | 46 ++++
 rtl/uart_rx_core.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants.
//   parity_mode_t   : run-time parity selection (NONE/EVEN/ODD/MARK/SPACE)
//   rx_state_t      : receiver frame states
//   UFIFO_DATA_WIDTH: default upstream FIFO word width {break, frame_err, parity_err, data}
//   WD_*_OFS        : flag positions above the data field of the FIFO word
//   clamp_data_bits : folds a requested data length into 5..max_bits
package uart_pkg;

    typedef enum logic [2:0] {
        ParNone  = 3'd0,
        ParEven  = 3'd1,
        ParOdd   = 3'd2,
        ParMark  = 3'd3,
        ParSpace = 3'd4
    } parity_mode_t;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } rx_state_t;

    localparam int unsigned UART_MAX_DATA_BITS_DEF = 9;
    localparam int unsigned UFIFO_DATA_WIDTH       = UART_MAX_DATA_BITS_DEF + 3;
    localparam int unsigned UART_MIN_DATA_BITS     = 5;

    // Flag bit positions, counted upward from the top of the data field.
    localparam int unsigned WD_PARITY_ERR_OFS = 0;
    localparam int unsigned WD_FRAME_ERR_OFS  = 1;
    localparam int unsigned WD_BREAK_OFS      = 2;

    function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits,
                                                   input logic [3:0] max_bits);
        if (bits < 4'(UART_MIN_DATA_BITS)) begin
            return 4'(UART_MIN_DATA_BITS);
        end
        if (bits > max_bits) begin
            return max_bits;
        end
        return bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Programmable oversample tick generator.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_run   : count while high; low holds the counter at 0
//   i_clear : restart the divider from 0 (takes priority over i_run)
//   i_div   : one tick every i_div+1 clocks
//   o_tick  : single-cycle oversample tick
module uart_baud_gen #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_run,
    input  logic                 i_clear,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 at_end;

    // >= rather than == so that lowering i_div mid-count cannot run the counter
    // all the way around its range.
    assign at_end = (cnt_q >= i_div);

    always_comb begin
        o_tick = i_run && !i_clear && at_end;
        cnt_d  = cnt_q;
        if (!i_run || i_clear) begin
            cnt_d = '0;
        end else if (at_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: oversampled, 2-of-3 mid-bit majority vote, run-time frame format.
//   i_apb_pclk / i_apb_presetn : clock, asynchronous active-low reset
//   i_enable          : receiver enable; low aborts the current frame
//   i_baud_div        : oversample tick every i_baud_div+1 clocks
//   i_data_bits       : data bits per frame (clamped to 5..MAX_DATA_BITS)
//   i_parity_mode     : parity_mode_t
//   i_stop2           : two stop bits when high
//   i_rx              : asynchronous serial input, idle high
//   i_ufifo_full      : upstream FIFO full
//   o_ufifo_write_req : one-cycle push strobe
//   o_ufifo_wdata     : {break, frame_err, parity_err, data}, valid with the strobe
//   o_rx_status       : busy from start detect until back in IDLE
//   o_overrun         : one-cycle pulse when a finished frame is dropped on a full FIFO
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE     = 16,
    parameter int unsigned MAX_DATA_BITS  = 9,
    parameter int unsigned BAUD_DIV_WIDTH = 16
) (
    input  logic                      i_apb_pclk,
    input  logic                      i_apb_presetn,
    input  logic                      i_enable,
    input  logic [BAUD_DIV_WIDTH-1:0] i_baud_div,
    input  logic [3:0]                i_data_bits,
    input  logic [2:0]                i_parity_mode,
    input  logic                      i_stop2,
    input  logic                      i_rx,
    input  logic                      i_ufifo_full,
    output logic                      o_ufifo_write_req,
    output logic [MAX_DATA_BITS+2:0]  o_ufifo_wdata,
    output logic                      o_rx_status,
    output logic                      o_overrun
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SMP_V0   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_V1   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SMP_V2   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
    localparam int unsigned PERR_IDX = MAX_DATA_BITS + WD_PARITY_ERR_OFS;
    localparam int unsigned FERR_IDX = MAX_DATA_BITS + WD_FRAME_ERR_OFS;
    localparam int unsigned BRK_IDX  = MAX_DATA_BITS + WD_BREAK_OFS;

    rx_state_t state_q, state_d;

    logic                     rx_s1_q, rx_s2_q;
    logic [SW-1:0]            sample_q, sample_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic                     stop_cnt_q, stop_cnt_d;
    logic [1:0]               v_q, v_d;
    logic [MAX_DATA_BITS-1:0] data_q, data_d;
    logic                     par_err_q, par_err_d;
    logic                     frm_err_q, frm_err_d;
    logic                     zero_q, zero_d;
    logic [3:0]               cfg_bits_q, cfg_bits_d;
    parity_mode_t             cfg_par_q, cfg_par_d;
    logic                     cfg_stop2_q, cfg_stop2_d;

    logic tick, run, start_det, vote, mid_vote, bit_end;
    logic last_data, last_stop, push, brk;

    assign run       = i_enable && (state_q != StIdle);
    assign start_det = i_enable && (state_q == StIdle) && !rx_s2_q;

    uart_baud_gen #(
        .DIV_WIDTH(BAUD_DIV_WIDTH)
    ) u_baud_gen (
        .i_clk  (i_apb_pclk),
        .i_rst_n(i_apb_presetn),
        .i_run  (run),
        .i_clear(start_det),
        .i_div  (i_baud_div),
        .o_tick (tick)
    );

    assign vote      = (v_q[0] & v_q[1]) | (v_q[0] & rx_s2_q) | (v_q[1] & rx_s2_q);
    assign mid_vote  = tick && (sample_q == SMP_V2);
    assign bit_end   = tick && (sample_q == SMP_LAST);
    assign last_data = (bit_cnt_q == cfg_bits_q - 4'd1);
    assign last_stop = (stop_cnt_q == cfg_stop2_q);
    // tick already implies i_enable, so a push can never happen on an aborted frame.
    assign push      = (state_q == StStop) && mid_vote && last_stop;
    // Break: every data/parity/stop vote so far low, including the current stop vote.
    assign brk       = zero_q && !vote;

    // State register
    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (!i_enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s2_q) state_d = StStart;
                end
                StStart: begin
                    if (mid_vote && vote) begin
                        state_d = StIdle;
                    end else if (bit_end) begin
                        state_d = StData;
                    end
                end
                StData: begin
                    if (bit_end && last_data) begin
                        state_d = (cfg_par_q == ParNone) ? StStop : StParity;
                    end
                end
                StParity: begin
                    if (bit_end) state_d = StStop;
                end
                StStop: begin
                    if (push) state_d = brk ? StBrkWait : StIdle;
                end
                StBrkWait: begin
                    if (rx_s2_q) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs
    always_comb begin
        o_rx_status       = (state_q != StIdle);
        o_ufifo_write_req = push && !i_ufifo_full;
        o_overrun         = push && i_ufifo_full;
        o_ufifo_wdata     = '0;
        if (push) begin
            o_ufifo_wdata[MAX_DATA_BITS-1:0] = data_q;
            o_ufifo_wdata[PERR_IDX]          = par_err_q;
            o_ufifo_wdata[FERR_IDX]          = frm_err_q || !vote;
            o_ufifo_wdata[BRK_IDX]           = brk;
        end
    end

    // Datapath next state
    always_comb begin
        sample_d    = sample_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        v_d         = v_q;
        data_d      = data_q;
        par_err_d   = par_err_q;
        frm_err_d   = frm_err_q;
        zero_d      = zero_q;
        cfg_bits_d  = cfg_bits_q;
        cfg_par_d   = cfg_par_q;
        cfg_stop2_d = cfg_stop2_q;

        if (tick) begin
            sample_d = (sample_q == SMP_LAST) ? '0 : sample_q + 1'b1;
            if (sample_q == SMP_V0) v_d[0] = rx_s2_q;
            if (sample_q == SMP_V1) v_d[1] = rx_s2_q;
        end

        if (mid_vote) begin
            case (state_q)
                StData: begin
                    for (int i = 0; i < int'(MAX_DATA_BITS); i++) begin
                        if (bit_cnt_q == 4'(i)) data_d[i] = vote;
                    end
                    zero_d = zero_q && !vote;
                end
                StParity: begin
                    case (cfg_par_q)
                        ParEven:  par_err_d = (^data_q) ^ vote;
                        ParOdd:   par_err_d = !((^data_q) ^ vote);
                        ParMark:  par_err_d = !vote;
                        ParSpace: par_err_d = vote;
                        default:  par_err_d = par_err_q;
                    endcase
                    zero_d = zero_q && !vote;
                end
                StStop: begin
                    if (!vote) frm_err_d = 1'b1;
                    zero_d = zero_q && !vote;
                end
                default: ;
            endcase
        end

        if (bit_end) begin
            if (state_q == StData) bit_cnt_d = bit_cnt_q + 4'd1;
            if (state_q == StStop) stop_cnt_d = 1'b1;
        end

        if (start_det) begin
            // The detect clock itself stands in for sample 0 of the start bit.
            sample_d    = SW'(1);
            bit_cnt_d   = '0;
            stop_cnt_d  = 1'b0;
            data_d      = '0;
            par_err_d   = 1'b0;
            frm_err_d   = 1'b0;
            zero_d      = 1'b1;
            cfg_bits_d  = clamp_data_bits(i_data_bits, 4'(MAX_DATA_BITS));
            cfg_stop2_d = i_stop2;
            if (i_parity_mode > 3'd4) begin
                cfg_par_d = ParNone;
            end else begin
                cfg_par_d = parity_mode_t'(i_parity_mode);
            end
        end else if (state_d == StIdle) begin
            sample_d   = '0;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
        end
    end

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            sample_q    <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            v_q         <= '0;
            data_q      <= '0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            zero_q      <= 1'b0;
            cfg_bits_q  <= '0;
            cfg_par_q   <= ParNone;
            cfg_stop2_q <= 1'b0;
        end else begin
            rx_s1_q     <= i_rx;
            rx_s2_q     <= rx_s1_q;
            sample_q    <= sample_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            v_q         <= v_d;
            data_q      <= data_d;
            par_err_q   <= par_err_d;
            frm_err_q   <= frm_err_d;
            zero_q      <= zero_d;
            cfg_bits_q  <= cfg_bits_d;
            cfg_par_q   <= cfg_par_d;
            cfg_stop2_q <= cfg_stop2_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: stimulus queues the expected push/overrun events,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_uart_rx_core;

    localparam int unsigned OS  = 16;
    localparam int unsigned MDB = 9;
    localparam int unsigned BDW = 16;
    localparam int unsigned WDW = MDB + 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [BDW-1:0] div = '0;
    logic [3:0]     dbits = 4'd8;
    logic [2:0]     pmode = 3'd0;
    logic           stop2 = 1'b0;
    logic           rx = 1'b1;
    logic           full = 1'b0;
    logic           wr, ovr, status;
    logic [WDW-1:0] wdata;

    uart_rx_core #(
        .OVERSAMPLE    (OS),
        .MAX_DATA_BITS (MDB),
        .BAUD_DIV_WIDTH(BDW)
    ) dut (
        .i_apb_pclk       (clk),
        .i_apb_presetn    (rst_n),
        .i_enable         (en),
        .i_baud_div       (div),
        .i_data_bits      (dbits),
        .i_parity_mode    (pmode),
        .i_stop2          (stop2),
        .i_rx             (rx),
        .i_ufifo_full     (full),
        .o_ufifo_write_req(wr),
        .o_ufifo_wdata    (wdata),
        .o_rx_status      (status),
        .o_overrun        (ovr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           ovr;
        logic           chk_lat;
        logic [WDW-1:0] wdata;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    int unsigned t_fall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_push(input logic o, input logic l, input logic [WDW-1:0] w);
        exp_t e;
        e.ovr     = o;
        e.chk_lat = l;
        e.wdata   = w;
        sb_q.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t        e;
        int unsigned lat;
        if (rst_n && (wr || ovr)) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_push: write_req=%0b overrun=%0b wdata=%0h, expected none",
                         wr, ovr, wdata);
            end else begin
                e = sb_q.pop_front();
                check("push_kind", {30'b0, wr, ovr}, {30'b0, !e.ovr, e.ovr});
                if (!e.ovr) check("wdata", 32'(wdata), 32'(e.wdata));
                if (e.chk_lat) begin
                    lat = cyc - t_fall;
                    n_checks++;
                    if (lat < 602 || lat > 614) begin
                        n_errors++;
                        $display("FAIL latency: got %0d clocks, expected 602..614", lat);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input int d, input int b, input int p, input int s);
        @(negedge clk);
        div   = BDW'(d);
        dbits = 4'(b);
        pmode = 3'(p);
        stop2 = s[0];
    endtask

    // force_par < 0 sends the correct parity bit for par_mode.
    task automatic send_frame(input logic [8:0] data, input int nbits, input int par_mode,
                              input int force_par, input int nstop, input int bit_clks);
        logic p;
        logic pb;
        @(negedge clk);
        rx     = 1'b0;
        t_fall = cyc;
        repeat (bit_clks) @(negedge clk);
        p = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            rx = data[i];
            p  = p ^ data[i];
            repeat (bit_clks) @(negedge clk);
        end
        if (par_mode != 0) begin
            case (par_mode)
                1:       pb = p;
                2:       pb = !p;
                3:       pb = 1'b1;
                default: pb = 1'b0;
            endcase
            if (force_par >= 0) pb = force_par[0];
            rx = pb;
            repeat (bit_clks) @(negedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            rx = 1'b1;
            repeat (bit_clks) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_status_low(input int max_clks, input string name);
        for (int i = 0; i < max_clks; i++) begin
            if (!status) break;
            @(negedge clk);
        end
        check(name, 32'(status), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_write_req", 32'(wr), 32'd0);
        check("rst_overrun", 32'(ovr), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        idle(5);
        check("idle_status", 32'(status), 32'd0);

        // 8N1, 64 clk/bit, with latency window
        cfg(3, 8, 0, 0);
        expect_push(1'b0, 1'b1, 12'h0A5);
        send_frame(9'h0A5, 8, 0, -1, 1, 64);
        check("t1_status_after", 32'(status), 32'd0);
        idle(128);

        // 7E2 with wrong parity bit
        cfg(3, 7, 1, 1);
        expect_push(1'b0, 1'b0, 12'h235);
        send_frame(9'h035, 7, 1, 1, 2, 64);
        idle(128);

        // 20-clock glitch while idle
        cfg(3, 8, 0, 0);
        @(negedge clk);
        rx = 1'b0;
        idle(10);
        check("glitch_status_hi", 32'(status), 32'd1);
        idle(10);
        rx = 1'b1;
        wait_status_low(44, "glitch_status_lo");
        idle(128);

        // Break: low for 12 bit times
        expect_push(1'b0, 1'b0, 12'hC00);
        @(negedge clk);
        rx = 1'b0;
        idle(12 * 64);
        check("brk_wait_status", 32'(status), 32'd1);
        rx = 1'b1;
        wait_status_low(8, "brk_release");
        idle(128);
        expect_push(1'b0, 1'b0, 12'h05A);
        send_frame(9'h05A, 8, 0, -1, 1, 64);
        idle(128);

        // FIFO full -> overrun, then normal write
        full = 1'b1;
        expect_push(1'b1, 1'b0, '0);
        send_frame(9'h03C, 8, 0, -1, 1, 64);
        full = 1'b0;
        idle(128);
        expect_push(1'b0, 1'b0, 12'h03C);
        send_frame(9'h03C, 8, 0, -1, 1, 64);
        idle(128);

        // 9-bit MARK parity
        cfg(3, 9, 3, 0);
        expect_push(1'b0, 1'b0, 12'h1FF);
        send_frame(9'h1FF, 9, 3, -1, 1, 64);
        idle(128);

        // Enable dropped mid-frame
        fork
            send_frame(9'h0AA, 9, 3, -1, 1, 64);
            begin
                idle(4 * 64 + 32);
                en = 1'b0;
                @(negedge clk);
                check("en_drop_status", 32'(status), 32'd0);
            end
        join
        en = 1'b1;
        idle(128);

        // Data length below 5 clamps to 5; divider 0 (16 clk/bit)
        cfg(0, 3, 0, 0);
        expect_push(1'b0, 1'b0, 12'h015);
        send_frame(9'h015, 5, 0, -1, 1, 16);
        idle(64);

        // 8O1 all-zero data with parity bit 1: not a break, no errors
        cfg(0, 8, 2, 0);
        expect_push(1'b0, 1'b0, 12'h000);
        send_frame(9'h000, 8, 2, -1, 1, 16);
        idle(64);

        // Config change mid-frame must not affect the frame in flight
        cfg(0, 8, 0, 0);
        expect_push(1'b0, 1'b0, 12'h081);
        fork
            send_frame(9'h081, 8, 0, -1, 1, 16);
            begin
                idle(40);
                dbits = 4'd5;
                pmode = 3'd1;
            end
        join
        idle(64);

        // Asynchronous reset mid-frame
        cfg(3, 8, 0, 0);
        fork
            send_frame(9'h055, 8, 0, -1, 1, 64);
            begin
                idle(200);
                #2 rst_n = 1'b0;
                #1;
                check("async_rst_status", 32'(status), 32'd0);
                check("async_rst_write_req", 32'(wr), 32'd0);
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        idle(128);

        for (int i = 0; i < 2000; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
